// File: rtl/crc_serial_engine.sv
// Serial CRC engine for the USB bit path: accumulate, residue check and
// complemented-CRC generation. Define CRC_ERR_CNT_EN to add err_cnt/err_clr.
module crc_serial_engine #(
    parameter int unsigned      WIDTH   = 16,
    parameter logic [WIDTH-1:0] POLY    = 16'h8005,
    parameter logic [WIDTH-1:0] INIT    = '1,
    parameter logic [WIDTH-1:0] RESIDUE = 16'h800D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             bit_en,
    input  logic             crc_en,
    input  logic             d_in,
    input  logic             gen_start,
    input  logic             check,
    output logic             crc_out,
    output logic             crc_out_valid,
    output logic             gen_busy,
    output logic             gen_done,
    output logic             check_valid,
    output logic             crc_ok,
    output logic [WIDTH-1:0] crc_value
`ifdef CRC_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt,
    input  logic             err_clr
`endif
);

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("crc_serial_engine: WIDTH must be within 3..32");
    end

    localparam int unsigned    CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {ACCUM, GEN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             gen_done_q, gen_done_d;
    logic             check_valid_q, check_valid_d;
    logic             crc_ok_q, crc_ok_d;
    logic             fb;
    logic [WIDTH-1:0] r_upd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ACCUM;
            r_q           <= INIT;
            cnt_q         <= '0;
            gen_done_q    <= 1'b0;
            check_valid_q <= 1'b0;
            crc_ok_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            r_q           <= r_d;
            cnt_q         <= cnt_d;
            gen_done_q    <= gen_done_d;
            check_valid_q <= check_valid_d;
            crc_ok_q      <= crc_ok_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        r_d           = r_q;
        cnt_d         = cnt_q;
        gen_done_d    = 1'b0;
        check_valid_d = 1'b0;
        crc_ok_d      = crc_ok_q;
        crc_out       = 1'b0;
        crc_out_valid = 1'b0;
        gen_busy      = 1'b0;
        fb            = d_in ^ r_q[WIDTH-1];
        r_upd         = {r_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

        case (state_q)
            ACCUM: begin
                if (gen_start) begin
                    state_d = GEN;
                    cnt_d   = '0;
                end else begin
                    // Compare sees the register before any same-cycle update.
                    if (check) begin
                        check_valid_d = 1'b1;
                        crc_ok_d      = (r_q == RESIDUE);
                    end
                    if (bit_en && crc_en) begin
                        r_d = r_upd;
                    end
                end
            end
            GEN: begin
                gen_busy      = 1'b1;
                crc_out       = ~r_q[WIDTH-1];
                crc_out_valid = bit_en;
                if (bit_en) begin
                    r_d = {r_q[WIDTH-2:0], 1'b0};
                    if (cnt_q == LAST) begin
                        state_d    = ACCUM;
                        gen_done_d = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase

        // init overrides whatever the state logic chose, in either state.
        if (init) begin
            state_d       = ACCUM;
            r_d           = INIT;
            cnt_d         = '0;
            gen_done_d    = 1'b0;
            check_valid_d = 1'b0;
            crc_ok_d      = crc_ok_q;
        end
    end

    assign crc_value   = r_q;
    assign gen_done    = gen_done_q;
    assign check_valid = check_valid_q;
    assign crc_ok      = crc_ok_q;

`ifdef CRC_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (err_clr) begin
            err_cnt_q <= '0;
        end else if (check_valid_q && !crc_ok_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc_serial_engine.sv
// Bench for crc_serial_engine: CRC5 instance, CRC16 transmitter and a CRC16
// receiver fed from the transmitter's serial output, all against a bench model.
module tb_crc_serial_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v, init_v, ben_v, cen_v, din_v, gs_v, chk_v;
    logic       loop_sel;
    logic       b_din;
    logic [2:0] co_v, cov_v, busy_v, gd_v, cvld_v, ok_v;
    logic [4:0]  cv5;
    logic [15:0] cv16a, cv16b;
    logic [31:0] cva [3];

    assign b_din  = loop_sel ? co_v[1] : din_v[2];
    assign cva[0] = {27'b0, cv5};
    assign cva[1] = {16'b0, cv16a};
    assign cva[2] = {16'b0, cv16b};

`ifdef CRC_ERR_CNT_EN
    logic [2:0] eclr_v;
    logic [7:0] ec5, ec16a, ec16b;
    logic [7:0] eca [3];
    assign eca[0] = ec5;
    assign eca[1] = ec16a;
    assign eca[2] = ec16b;
`endif

    crc_serial_engine #(.WIDTH(5), .POLY(5'h05), .INIT(5'h1F), .RESIDUE(5'h0C)) u5 (
        .clk(clk), .rst(rst_v[0]), .init(init_v[0]), .bit_en(ben_v[0]), .crc_en(cen_v[0]),
        .d_in(din_v[0]), .gen_start(gs_v[0]), .check(chk_v[0]), .crc_out(co_v[0]),
        .crc_out_valid(cov_v[0]), .gen_busy(busy_v[0]), .gen_done(gd_v[0]),
        .check_valid(cvld_v[0]), .crc_ok(ok_v[0]), .crc_value(cv5)
`ifdef CRC_ERR_CNT_EN
        , .err_cnt(ec5), .err_clr(eclr_v[0])
`endif
    );

    crc_serial_engine #(.WIDTH(16), .POLY(16'h8005), .INIT(16'hFFFF), .RESIDUE(16'h800D)) u16a (
        .clk(clk), .rst(rst_v[1]), .init(init_v[1]), .bit_en(ben_v[1]), .crc_en(cen_v[1]),
        .d_in(din_v[1]), .gen_start(gs_v[1]), .check(chk_v[1]), .crc_out(co_v[1]),
        .crc_out_valid(cov_v[1]), .gen_busy(busy_v[1]), .gen_done(gd_v[1]),
        .check_valid(cvld_v[1]), .crc_ok(ok_v[1]), .crc_value(cv16a)
`ifdef CRC_ERR_CNT_EN
        , .err_cnt(ec16a), .err_clr(eclr_v[1])
`endif
    );

    crc_serial_engine #(.WIDTH(16), .POLY(16'h8005), .INIT(16'hFFFF), .RESIDUE(16'h800D)) u16b (
        .clk(clk), .rst(rst_v[2]), .init(init_v[2]), .bit_en(ben_v[2]), .crc_en(cen_v[2]),
        .d_in(b_din), .gen_start(gs_v[2]), .check(chk_v[2]), .crc_out(co_v[2]),
        .crc_out_valid(cov_v[2]), .gen_busy(busy_v[2]), .gen_done(gd_v[2]),
        .check_valid(cvld_v[2]), .crc_ok(ok_v[2]), .crc_value(cv16b)
`ifdef CRC_ERR_CNT_EN
        , .err_cnt(ec16b), .err_clr(eclr_v[2])
`endif
    );

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    int unsigned WD  [3] = '{5, 16, 16};
    logic [31:0] PD  [3] = '{32'h05, 32'h8005, 32'h8005};
    logic [31:0] RSD [3] = '{32'h0C, 32'h800D, 32'h800D};

    // Model state: m_r holds the accumulated CRC; during generation the
    // transmitted field is m_field, and m_cnt bits of it have gone out.
    logic [31:0] m_r [3];
    logic [31:0] m_field [3];
    bit          m_gen [3];
    int unsigned m_cnt [3];
    bit          m_gd [3], m_cv [3], m_ok [3];
    int          m_err [3];

    bit          out5 [$];

    function automatic logic [31:0] mask_of(input int i);
        return (WD[i] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << WD[i]) - 32'd1);
    endfunction

    function automatic logic [31:0] crc_upd(input int i, input logic [31:0] r, input logic d);
        logic fbk;
        fbk = d ^ r[WD[i]-1];
        return ((r << 1) & mask_of(i)) ^ (fbk ? PD[i] : 32'h0);
    endfunction

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [31:0] msk;
            logic        d;
            bit          gd_n, cv_n;
            msk  = mask_of(i);
            d    = (i == 2) ? b_din : din_v[i];
            gd_n = 1'b0;
            cv_n = 1'b0;
            if (rst_v[i]) begin
                m_r[i] = msk; m_field[i] = '0; m_gen[i] = 1'b0; m_cnt[i] = 0;
                m_ok[i] = 1'b0; m_err[i] = 0;
            end else begin
`ifdef CRC_ERR_CNT_EN
                if (eclr_v[i]) m_err[i] = 0;
                else if (m_cv[i] && !m_ok[i] && m_err[i] < 255) m_err[i]++;
`endif
                if (init_v[i]) begin
                    m_r[i] = msk; m_gen[i] = 1'b0; m_cnt[i] = 0;
                end else if (m_gen[i]) begin
                    if (ben_v[i]) begin
                        m_cnt[i]++;
                        if (m_cnt[i] == WD[i]) begin
                            m_gen[i] = 1'b0; m_cnt[i] = 0; m_r[i] = '0; gd_n = 1'b1;
                        end
                    end
                end else if (gs_v[i]) begin
                    m_gen[i] = 1'b1; m_cnt[i] = 0; m_field[i] = ~m_r[i] & msk;
                end else begin
                    if (chk_v[i]) begin
                        cv_n = 1'b1; m_ok[i] = (m_r[i] == RSD[i]);
                    end
                    if (ben_v[i] && cen_v[i]) m_r[i] = crc_upd(i, m_r[i], d);
                end
            end
            m_gd[i] = gd_n;
            m_cv[i] = cv_n;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                logic [31:0] exp_v;
                logic        exp_o;
                exp_v = m_gen[i] ? ((m_r[i] << m_cnt[i]) & mask_of(i)) : m_r[i];
                exp_o = m_gen[i] ? m_field[i][WD[i]-1-m_cnt[i]] : 1'b0;
                expect_eq($sformatf("crc_value[%0d]", i), cva[i], exp_v);
                expect_eq($sformatf("crc_out[%0d]", i), 32'(co_v[i]), 32'(exp_o));
                expect_eq($sformatf("crc_out_valid[%0d]", i), 32'(cov_v[i]), 32'(m_gen[i] & ben_v[i]));
                expect_eq($sformatf("gen_busy[%0d]", i), 32'(busy_v[i]), 32'(m_gen[i]));
                expect_eq($sformatf("gen_done[%0d]", i), 32'(gd_v[i]), 32'(m_gd[i]));
                expect_eq($sformatf("check_valid[%0d]", i), 32'(cvld_v[i]), 32'(m_cv[i]));
                expect_eq($sformatf("crc_ok[%0d]", i), 32'(ok_v[i]), 32'(m_ok[i]));
`ifdef CRC_ERR_CNT_EN
                expect_eq($sformatf("err_cnt[%0d]", i), 32'(eca[i]), 32'(m_err[i]));
`endif
            end
            if (cov_v[0]) out5.push_back(co_v[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        rst_v = '0; init_v = '0; ben_v = '0; gs_v = '0; chk_v = '0;
        cen_v = 3'($urandom);
        din_v = 3'($urandom);
`ifdef CRC_ERR_CNT_EN
        eclr_v = '0;
`endif
    endtask

    // Sends n bits, bits[0] first, each preceded by a random 0..3 cycle gap.
    task automatic send_bits(input logic [2:0] sel, input logic [31:0] bits, input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) begin
                idle();
                tick();
            end
            idle();
            for (int i = 0; i < 3; i++) begin
                if (sel[i]) begin
                    ben_v[i] = 1'b1; cen_v[i] = 1'b1; din_v[i] = bits[k];
                end
            end
            tick();
            idle();
        end
    endtask

    initial begin
        logic [31:0] seq;
        loop_sel = 1'b0;
        idle();
        rst_v = 3'b111;
        tick();
        started = 1'b1;
        tick();
        idle();
        tick();
        expect_eq("reset crc5 value", cva[0], 32'h1F);
        expect_eq("reset crc16 value", cva[1], 32'hFFFF);
        expect_eq("reset busy/done/valid/ok", {28'b0, busy_v[0], gd_v[0], cvld_v[0], ok_v[0]}, 32'h0);

        // CRC5 over 11 zero bits, then generate the field.
        init_v[0] = 1'b1; tick(); idle();
        send_bits(3'b001, 32'h0, 11);
        expect_eq("crc5 11 zeros value", cva[0], 32'h17);
        out5.delete();
        gs_v[0] = 1'b1; tick(); idle();
        send_bits(3'b001, $urandom, 5);
        expect_eq("crc5 gen_done after 5th bit", 32'(gd_v[0]), 32'h1);
        expect_eq("crc5 gen_busy after field", 32'(busy_v[0]), 32'h0);
        seq = '0;
        foreach (out5[k]) seq = (seq << 1) | 32'(out5[k]);
        expect_eq("crc5 emitted bit count", 32'(out5.size()), 32'd5);
        expect_eq("crc5 emitted sequence 0,1,0,0,0", seq, 32'b01000);
        tick();
        expect_eq("crc5 gen_done is one cycle", 32'(gd_v[0]), 32'h0);

        // Corrupted last CRC bit must fail the residue compare.
        init_v[0] = 1'b1; tick(); idle();
        send_bits(3'b001, 32'h9000, 16);
        chk_v[0] = 1'b1; tick(); idle();
        expect_eq("crc5 bad check_valid", 32'(cvld_v[0]), 32'h1);
        expect_eq("crc5 bad crc_ok", 32'(ok_v[0]), 32'h0);
        tick();
`ifdef CRC_ERR_CNT_EN
        expect_eq("err_cnt after one bad check", 32'(ec5), 32'h1);
        chk_v[0] = 1'b1;
        repeat (260) tick();
        idle(); tick(); tick();
        expect_eq("err_cnt saturates", 32'(ec5), 32'hFF);
        eclr_v[0] = 1'b1; tick(); idle();
        expect_eq("err_cnt cleared", 32'(ec5), 32'h0);
`endif

        // Good CRC5 token: residue compare passes.
        init_v[0] = 1'b1; tick(); idle();
        send_bits(3'b001, 32'h1000, 16);
        chk_v[0] = 1'b1; tick(); idle();
        expect_eq("crc5 good check_valid", 32'(cvld_v[0]), 32'h1);
        expect_eq("crc5 good crc_ok", 32'(ok_v[0]), 32'h1);
        expect_eq("crc5 residue value", cva[0], 32'h0C);
        tick();
        expect_eq("crc5 check_valid is one cycle", 32'(cvld_v[0]), 32'h0);

        // init during bit 2 of generation aborts it; crc_ok is kept.
        init_v[0] = 1'b1; tick(); idle();
        send_bits(3'b001, $urandom, 3);
        gs_v[0] = 1'b1; tick(); idle();
        send_bits(3'b001, 32'h0, 2);
        init_v[0] = 1'b1; tick(); idle();
        expect_eq("abort gen_busy", 32'(busy_v[0]), 32'h0);
        expect_eq("abort value is INIT", cva[0], 32'h1F);
        expect_eq("abort crc_ok kept", 32'(ok_v[0]), 32'h1);
        tick();
        expect_eq("abort no gen_done", 32'(gd_v[0]), 32'h0);

        // CRC16 over bytes 0x00,0x01, generated field looped into the receiver.
        init_v = 3'b110; tick(); idle();
        send_bits(3'b110, 32'h0100, 16);
        gs_v[1] = 1'b1; tick(); idle();
        loop_sel = 1'b1;
        send_bits(3'b110, 32'h0, 16);
        expect_eq("crc16 gen_done", 32'(gd_v[1]), 32'h1);
        loop_sel = 1'b0;
        chk_v[2] = 1'b1; tick(); idle();
        expect_eq("crc16 loopback check_valid", 32'(cvld_v[2]), 32'h1);
        expect_eq("crc16 loopback crc_ok", 32'(ok_v[2]), 32'h1);
        expect_eq("crc16 loopback residue", cva[2], 32'h800D);

        // rst in the middle of a packet / generation.
        init_v = 3'b111; tick(); idle();
        send_bits(3'b111, $urandom, 4);
        gs_v[0] = 1'b1; tick(); idle();
        send_bits(3'b001, 32'h0, 1);
        rst_v = 3'b111; tick(); idle();
        expect_eq("rst crc5 value", cva[0], 32'h1F);
        expect_eq("rst crc16 value", cva[1], 32'hFFFF);
        expect_eq("rst outputs", {26'b0, busy_v[0], gd_v[0], cvld_v[0], ok_v[0], co_v[0], ok_v[2]}, 32'h0);

        // Randomised traffic on all instances.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                rst_v[i]  = ($urandom_range(0, 299) == 0);
                init_v[i] = ($urandom_range(0, 59) == 0);
                ben_v[i]  = ($urandom_range(0, 3) != 0);
                cen_v[i]  = ($urandom_range(0, 7) != 0);
                din_v[i]  = 1'($urandom);
                gs_v[i]   = ($urandom_range(0, 24) == 0);
                chk_v[i]  = ($urandom_range(0, 19) == 0);
`ifdef CRC_ERR_CNT_EN
                eclr_v[i] = ($urandom_range(0, 49) == 0);
`endif
            end
            loop_sel = 1'($urandom);
            tick();
        end
        idle();
        loop_sel = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
